controle_excecao: RTL and testbench

//  Exception sequencer of the multicycle CPU; drives the 2-bit select of the exception-vector mux
//  (00=253 invalid opcode, 01=254 overflow, 10=255 divide-by-zero). On a fault it saves EPC and

---
 rtl/controle_excecao_pkg.sv | 36 +++
 rtl/controle_excecao_prioridade.sv | 26 ++
 rtl/controle_excecao.sv | 143 ++++++++++++++
 tb/tb_controle_excecao.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_excecao_pkg.sv
// Shared definitions for the exception sequencer: sequencer states,
// cause codes (also the vector-mux select) and the vector byte addresses.
package controle_excecao_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    SALVA_EPC  = 2'b01,
    LE_MEM     = 2'b10,
    CARREGA_PC = 2'b11
  } estado_t;

  // Cause encoding doubles as the select of the exception-vector mux
  localparam logic [1:0] CAUSA_OPCODE = 2'b00;
  localparam logic [1:0] CAUSA_OVF    = 2'b01;
  localparam logic [1:0] CAUSA_DIV0   = 2'b10;

  // Memory addresses the vector mux presents for each cause
  localparam logic [7:0] VETOR_OPCODE = 8'd253;
  localparam logic [7:0] VETOR_OVF    = 8'd254;
  localparam logic [7:0] VETOR_DIV0   = 8'd255;

  // Width of the memory wait counter (MEM_WAIT is limited to 0..7)
  localparam int CONT_W = 3;

  // Vector address selected by a given cause code
  function automatic logic [7:0] vetor_da_causa(input logic [1:0] causa);
    logic [7:0] v;
    case (causa)
      CAUSA_OVF:  v = VETOR_OVF;
      CAUSA_DIV0: v = VETOR_DIV0;
      default:    v = VETOR_OPCODE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/controle_excecao_prioridade.sv
// Combinational 3->2 priority encoder for the fault pulses.
// Priority: invalid opcode > divide-by-zero > overflow.
module prioridade_excecao
  import controle_excecao_pkg::*;
(
  input  logic       opcode_invalido_i,
  input  logic       div_zero_i,
  input  logic       overflow_i,
  output logic       falha_o,
  output logic [1:0] codigo_o
);

  // Flag any fault and encode the highest-priority one
  always_comb begin
    falha_o  = opcode_invalido_i | div_zero_i | overflow_i;
    codigo_o = CAUSA_OPCODE;
    if (opcode_invalido_i) begin
      codigo_o = CAUSA_OPCODE;
    end else if (div_zero_i) begin
      codigo_o = CAUSA_DIV0;
    end else if (overflow_i) begin
      codigo_o = CAUSA_OVF;
    end
  end

endmodule

// File: rtl/controle_excecao.sv
// Exception sequencer of the multicycle CPU. On a fault it latches the
// cause (which also drives the vector-mux select), saves EPC, reads the
// handler byte through the vector mux and loads it into PC. A return
// request while idle reloads PC from EPC. pc_escrita and pc_novo are
// registered, so the PC write appears the cycle after CARREGA_PC.
module controle_excecao
  import controle_excecao_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            opcode_invalido,
  input  logic            overflow,
  input  logic            div_zero,
  input  logic            retorno,
  input  logic [PC_W-1:0] pc_atual,
  input  logic [PC_W-1:0] mem_dado,
  output logic [1:0]      controle,
  output logic            sel_end_excecao,
  output logic            mem_ler,
  output logic            pc_escrita,
  output logic [PC_W-1:0] pc_novo,
  output logic [PC_W-1:0] epc,
  output logic [1:0]      causa,
  output logic            ocupado,
  output logic            falha_dupla
);

  localparam logic [PC_W-1:0]   QUATRO = PC_W'(4);
  localparam logic [CONT_W-1:0] ESPERA = CONT_W'(MEM_WAIT);

  estado_t           estado_q, estado_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic [1:0]        causa_q, causa_d;
  logic [1:0]        controle_q, controle_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [PC_W-1:0]   pc_novo_q, pc_novo_d;
  logic              pc_escrita_q, pc_escrita_d;
  logic              falha_dupla_q, falha_dupla_d;

  logic              falha;
  logic [1:0]        codigo;

  // Only the low byte of the memory word carries the handler address
  logic              unused_mem_alto;
  assign unused_mem_alto = ^mem_dado[PC_W-1:8];

  prioridade_excecao u_prioridade (
    .opcode_invalido_i (opcode_invalido),
    .div_zero_i        (div_zero),
    .overflow_i        (overflow),
    .falha_o           (falha),
    .codigo_o          (codigo)
  );

  // State and data registers; reset aborts any sequence immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= OCIOSO;
      cont_q        <= '0;
      causa_q       <= CAUSA_OPCODE;
      controle_q    <= CAUSA_OPCODE;
      epc_q         <= '0;
      pc_novo_q     <= '0;
      pc_escrita_q  <= 1'b0;
      falha_dupla_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cont_q        <= cont_d;
      causa_q       <= causa_d;
      controle_q    <= controle_d;
      epc_q         <= epc_d;
      pc_novo_q     <= pc_novo_d;
      pc_escrita_q  <= pc_escrita_d;
      falha_dupla_q <= falha_dupla_d;
    end
  end

  // Next-state sequencing and register updates
  always_comb begin
    estado_d      = estado_q;
    cont_d        = cont_q;
    causa_d       = causa_q;
    controle_d    = controle_q;
    epc_d         = epc_q;
    pc_novo_d     = pc_novo_q;
    pc_escrita_d  = 1'b0;
    falha_dupla_d = falha_dupla_q;

    // A fault while the sequencer is busy is only recorded, never served
    if (falha && (estado_q != OCIOSO)) begin
      falha_dupla_d = 1'b1;
    end

    case (estado_q)
      OCIOSO: begin
        if (falha) begin
          estado_d   = SALVA_EPC;
          causa_d    = codigo;
          controle_d = codigo;
        end else if (retorno) begin
          pc_novo_d    = epc_q;
          pc_escrita_d = 1'b1;
        end
      end
      SALVA_EPC: begin
        // pc_atual already points past the faulting instruction
        epc_d    = pc_atual - QUATRO;
        cont_d   = '0;
        estado_d = LE_MEM;
      end
      LE_MEM: begin
        if (cont_q == ESPERA) begin
          cont_d   = '0;
          estado_d = CARREGA_PC;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      CARREGA_PC: begin
        pc_novo_d    = {{(PC_W-8){1'b0}}, mem_dado[7:0]};
        pc_escrita_d = 1'b1;
        estado_d     = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign controle        = controle_q;
  assign causa           = causa_q;
  assign epc             = epc_q;
  assign pc_novo         = pc_novo_q;
  assign pc_escrita      = pc_escrita_q;
  assign falha_dupla     = falha_dupla_q;
  assign ocupado         = (estado_q != OCIOSO);
  assign mem_ler         = (estado_q == LE_MEM);
  assign sel_end_excecao = (estado_q == LE_MEM);

endmodule

// File: tb/tb_controle_excecao.sv
// Self-checking bench for controle_excecao: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// timestamp-based model of the exception sequence.
module tb_controle_excecao;
  import controle_excecao_pkg::*;

  localparam int PC_W = 32;
  localparam int MW   = 1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            opcode_invalido = 1'b0;
  logic            overflow = 1'b0;
  logic            div_zero = 1'b0;
  logic            retorno = 1'b0;
  logic [PC_W-1:0] pc_atual = '0;
  logic [PC_W-1:0] mem_dado = '0;
  logic [1:0]      controle;
  logic            sel_end_excecao;
  logic            mem_ler;
  logic            pc_escrita;
  logic [PC_W-1:0] pc_novo;
  logic [PC_W-1:0] epc;
  logic [1:0]      causa;
  logic            ocupado;
  logic            falha_dupla;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  controle_excecao #(.PC_W(PC_W), .MEM_WAIT(MW)) dut (
    .clock           (clock),
    .reset           (reset),
    .opcode_invalido (opcode_invalido),
    .overflow        (overflow),
    .div_zero        (div_zero),
    .retorno         (retorno),
    .pc_atual        (pc_atual),
    .mem_dado        (mem_dado),
    .controle        (controle),
    .sel_end_excecao (sel_end_excecao),
    .mem_ler         (mem_ler),
    .pc_escrita      (pc_escrita),
    .pc_novo         (pc_novo),
    .epc             (epc),
    .causa           (causa),
    .ocupado         (ocupado),
    .falha_dupla     (falha_dupla)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nome, got, want, $time);
    end
  endtask

  // Model: remembers the edge index at which a fault was accepted; every
  // output follows from the distance to that edge.
  int          cyc = 0;
  int          t_f = -1000;
  logic [1:0]  m_causa = 2'b00;
  logic [31:0] m_epc = '0;
  logic [31:0] m_pc_novo = '0;
  logic        m_pc_escrita = 1'b0;
  logic        m_fd = 1'b0;

  always @(posedge clock or negedge reset) begin : modelo
    int  d;
    bit  falha, ocup_antes;
    logic [1:0] cod;
    if (!reset) begin
      t_f = -1000;
      m_causa = 2'b00;
      m_epc = '0;
      m_pc_novo = '0;
      m_pc_escrita = 1'b0;
      m_fd = 1'b0;
    end else begin
      cyc++;
      d = cyc - t_f;
      falha = opcode_invalido || div_zero || overflow;
      cod = opcode_invalido ? CAUSA_OPCODE : (div_zero ? CAUSA_DIV0 : CAUSA_OVF);
      // Busy from the cycle after the fault edge through the load cycle
      ocup_antes = (d >= 1) && (d <= MW + 3);
      m_pc_escrita = 1'b0;
      if (ocup_antes && falha) m_fd = 1'b1;
      if (d == 1) m_epc = pc_atual - 32'd4;
      if (d == MW + 3) begin
        m_pc_novo = {24'h0, mem_dado[7:0]};
        m_pc_escrita = 1'b1;
      end
      if (!ocup_antes) begin
        if (falha) begin
          t_f = cyc;
          m_causa = cod;
        end else if (retorno) begin
          m_pc_novo = m_epc;
          m_pc_escrita = 1'b1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clock) begin : comparador
    int dn;
    bit e_ocup, e_mem;
    if (chk_en) begin
      dn = cyc - t_f;
      e_ocup = reset && (dn >= 0) && (dn <= MW + 2);
      e_mem  = reset && (dn >= 1) && (dn <= MW + 1);
      chk("cmp_controle", {30'h0, controle}, {30'h0, m_causa});
      chk("cmp_causa", {30'h0, causa}, {30'h0, m_causa});
      chk("cmp_epc", epc, m_epc);
      chk("cmp_pc_novo", pc_novo, m_pc_novo);
      chk("cmp_pc_escrita", {31'h0, pc_escrita}, {31'h0, m_pc_escrita});
      chk("cmp_ocupado", {31'h0, ocupado}, {31'h0, e_ocup});
      chk("cmp_mem_ler", {31'h0, mem_ler}, {31'h0, e_mem});
      chk("cmp_sel_end", {31'h0, sel_end_excecao}, {31'h0, e_mem});
      chk("cmp_falha_dupla", {31'h0, falha_dupla}, {31'h0, m_fd});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic limpa();
    opcode_invalido = 1'b0;
    overflow = 1'b0;
    div_zero = 1'b0;
    retorno = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_ocupado", {31'h0, ocupado}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_controle", {30'h0, controle}, 32'h0);
    chk("rst_pc_escrita", {31'h0, pc_escrita}, 32'h0);
    reset = 1'b1;
    tick();

    // 1: overflow, MEM_WAIT=1
    pc_atual = 32'h40; mem_dado = 32'h80; overflow = 1'b1;
    tick(); limpa();
    chk("t1_causa", {30'h0, causa}, 32'h1);
    chk("t1_ocupado", {31'h0, ocupado}, 32'h1);
    tick();
    chk("t1_epc", epc, 32'h3C);
    chk("t1_mem_ler_a", {31'h0, mem_ler}, 32'h1);
    tick();
    chk("t1_mem_ler_b", {31'h0, mem_ler}, 32'h1);
    tick();
    chk("t1_mem_ler_c", {31'h0, mem_ler}, 32'h0);
    chk("t1_pc_escrita_cedo", {31'h0, pc_escrita}, 32'h0);
    tick();
    chk("t1_pc_escrita", {31'h0, pc_escrita}, 32'h1);
    chk("t1_pc_novo", pc_novo, 32'h80);
    chk("t1_model_epc", m_epc, 32'h3C);
    chk("t1_model_pc_novo", m_pc_novo, 32'h80);
    tick();
    chk("t1_pc_escrita_fim", {31'h0, pc_escrita}, 32'h0);

    // 2: all three faults on one edge
    pc_atual = 32'h100; mem_dado = 32'h11;
    opcode_invalido = 1'b1; div_zero = 1'b1; overflow = 1'b1;
    tick(); limpa();
    chk("t2_causa", {30'h0, causa}, 32'h0);
    chk("t2_controle", {30'h0, controle}, 32'h0);
    repeat (4) tick();
    chk("t2_pc_escrita", {31'h0, pc_escrita}, 32'h1);
    chk("t2_pc_novo", pc_novo, 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_uma_seq_ocupado", {31'h0, ocupado}, 32'h0);
      chk("t2_uma_seq_pc_escrita", {31'h0, pc_escrita}, 32'h0);
    end

    // 3: div_zero, then return from exception
    pc_atual = 32'h200; mem_dado = 32'h22; div_zero = 1'b1;
    tick(); limpa();
    chk("t3_causa", {30'h0, causa}, 32'h2);
    repeat (4) tick();
    chk("t3_pc_novo", pc_novo, 32'h22);
    tick();
    retorno = 1'b1;
    tick(); limpa();
    chk("t3_ret_pc_escrita", {31'h0, pc_escrita}, 32'h1);
    chk("t3_ret_pc_novo", pc_novo, 32'h1FC);
    chk("t3_controle_mantido", {30'h0, controle}, 32'h2);
    tick();
    chk("t3_ret_um_ciclo", {31'h0, pc_escrita}, 32'h0);

    // 4: overflow while reading memory -> double fault
    pc_atual = 32'h300; mem_dado = 32'h44; div_zero = 1'b1;
    tick(); limpa();
    tick();
    overflow = 1'b1;
    tick(); limpa();
    chk("t4_falha_dupla", {31'h0, falha_dupla}, 32'h1);
    chk("t4_causa", {30'h0, causa}, 32'h2);
    chk("t4_epc", epc, 32'h2FC);
    repeat (2) tick();
    chk("t4_pc_escrita", {31'h0, pc_escrita}, 32'h1);
    chk("t4_pc_novo", pc_novo, 32'h44);
    tick();

    // 6: EPC wraps below zero, only the low byte of mem_dado is used
    pc_atual = 32'h0; mem_dado = 32'hFFFFFF37; div_zero = 1'b1;
    tick(); limpa();
    tick();
    chk("t6_epc", epc, 32'hFFFFFFFC);
    repeat (3) tick();
    chk("t6_pc_escrita", {31'h0, pc_escrita}, 32'h1);
    chk("t6_pc_novo", pc_novo, 32'h37);
    tick();

    // 5: reset mid-read aborts the sequence
    pc_atual = 32'h500; mem_dado = 32'h55; overflow = 1'b1;
    tick(); limpa();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("t5_ocupado", {31'h0, ocupado}, 32'h0);
    chk("t5_mem_ler", {31'h0, mem_ler}, 32'h0);
    chk("t5_epc", epc, 32'h0);
    chk("t5_causa", {30'h0, causa}, 32'h0);
    chk("t5_falha_dupla", {31'h0, falha_dupla}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_sem_pc_escrita", {31'h0, pc_escrita}, 32'h0);
    end
    reset = 1'b1;
    tick();

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      opcode_invalido = ($urandom_range(0, 19) == 0);
      div_zero        = ($urandom_range(0, 19) == 0);
      overflow        = ($urandom_range(0, 19) == 0);
      retorno         = ($urandom_range(0, 6) == 0);
      pc_atual        = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      mem_dado        = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
      end
      tick();
    end
    limpa();
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
